// File: rtl/serial_tx_scheduler_pkg.sv
// Shared constants for the serial byte scheduler: byte/slot geometry and defaults.
package serial_tx_scheduler_pkg;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned SLOT_CNT_W        = 3;
  localparam logic [SLOT_CNT_W-1:0] SLOT_LAST = 3'd0;
  localparam logic [BYTE_W-1:0] IDLE_BYTE_DEFAULT = 8'h00;
  localparam int unsigned MAX_REQ           = 4;
  localparam int unsigned GRANT_W           = 2;

endpackage

// File: rtl/serial_tx_scheduler_if.sv
// Requester-side byte handshake bundle (valid/ready per requester, packed data).
interface serial_tx_scheduler_if #(
  parameter int unsigned NUM_REQ = 2
);
  import serial_tx_scheduler_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (output req_valid, output req_data, input  req_ready);
  modport slave  (input  req_valid, input  req_data, output req_ready);

endinterface

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// Combinational round-robin picker; search starts one past the last granted index.
module rr_arbiter
  import serial_tx_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last_granted,
  output logic [NUM_REQ-1:0] grant,
  output logic [GRANT_W-1:0] grant_id
);

  localparam int unsigned IDX_W = GRANT_W + 1;

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = '0;
    found    = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'(last_granted) + IDX_W'(k);
      if (idx >= IDX_W'(NUM_REQ)) idx = idx - IDX_W'(NUM_REQ);
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && (idx == IDX_W'(j)) && req[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          grant_id = GRANT_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Never-stalling serial lane: one byte per 8-clock slot, MSB first, round-robin
// among byte requesters with IDLE_BYTE fill when nothing is granted.
module serial_tx_scheduler
  import serial_tx_scheduler_pkg::*;
#(
  parameter int unsigned       NUM_REQ   = 2,
  parameter logic [BYTE_W-1:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic                 clk_400MHz,
  input  logic                 reset,
  input  logic                 enable,
  serial_tx_scheduler_if.slave bus,
  output logic                 data_out,
  output logic                 byte_sync,
  output logic                 tx_busy,
  output logic [GRANT_W-1:0]   tx_grant_id
);

  logic [SLOT_CNT_W-1:0] slot_cnt;
  logic [BYTE_W-1:0]     shreg;
  logic [GRANT_W-1:0]    last_granted;
  logic [NUM_REQ-1:0]    grant;
  logic [GRANT_W-1:0]    grant_id;
  logic [BYTE_W-1:0]     sel_byte;
  logic                  boundary_c;
  logic                  take_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req          (bus.req_valid),
    .last_granted (last_granted),
    .grant        (grant),
    .grant_id     (grant_id)
  );

  assign boundary_c    = (slot_cnt == SLOT_LAST);
  assign take_c        = boundary_c && enable && (|grant);
  assign bus.req_ready = take_c ? grant : '0;
  assign data_out      = shreg[BYTE_W-1];

  // Byte of the winning requester; IDLE_BYTE when nobody wins.
  always_comb begin
    sel_byte = IDLE_BYTE;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_byte = bus.req_data[i*BYTE_W +: BYTE_W];
    end
  end

  // Slot counter, shifter and per-slot status all advance together.
  always_ff @(posedge clk_400MHz or posedge reset) begin
    if (reset) begin
      slot_cnt     <= '1;
      shreg        <= IDLE_BYTE;
      last_granted <= GRANT_W'(NUM_REQ - 1);
      byte_sync    <= 1'b1;
      tx_busy      <= 1'b0;
      tx_grant_id  <= '0;
    end else if (boundary_c) begin
      slot_cnt  <= '1;
      byte_sync <= 1'b1;
      if (take_c) begin
        shreg        <= sel_byte;
        tx_busy      <= 1'b1;
        tx_grant_id  <= grant_id;
        last_granted <= grant_id;
      end else begin
        shreg       <= IDLE_BYTE;
        tx_busy     <= 1'b0;
        tx_grant_id <= '0;
      end
    end else begin
      slot_cnt  <= slot_cnt - 1'b1;
      shreg     <= {shreg[BYTE_W-2:0], 1'b0};
      byte_sync <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed bench: deserializes each 8-clock slot aligned to byte_sync and checks
// byte content, status outputs and the ready pulses against hand-computed values.
module tb_serial_tx_scheduler;

  logic       clk_400MHz = 1'b0;
  logic       reset;
  logic       enable;
  logic       data_out;
  logic       byte_sync;
  logic       tx_busy;
  logic [1:0] tx_grant_id;

  int total = 0;
  int bad   = 0;

  serial_tx_scheduler_if #(.NUM_REQ(2)) bus ();

  serial_tx_scheduler #(.NUM_REQ(2), .IDLE_BYTE(8'h00)) dut (
    .clk_400MHz  (clk_400MHz),
    .reset       (reset),
    .enable      (enable),
    .bus         (bus),
    .data_out    (data_out),
    .byte_sync   (byte_sync),
    .tx_busy     (tx_busy),
    .tx_grant_id (tx_grant_id)
  );

  always #5 clk_400MHz = ~clk_400MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge where bit 7 of a slot is on the lane; returns at the next slot's bit 7.
  task automatic read_slot(input logic toggle_en, output logic [7:0] b, output logic busy,
                           output logic [1:0] id, output int sync_err, output int stray_ready,
                           output logic [1:0] bnd_ready);
    b = '0; sync_err = 0; stray_ready = 0; bnd_ready = '0;
    busy = tx_busy; id = tx_grant_id;
    for (int i = 0; i < 8; i++) begin
      b[7-i] = data_out;
      if (byte_sync !== (i == 0)) sync_err++;
      if ((tx_busy !== busy) || (tx_grant_id !== id)) sync_err++;
      if (i == 7) bnd_ready = bus.req_ready;
      else if (bus.req_ready !== 2'b00) stray_ready++;
      if (toggle_en && i == 2) enable = 1'b0;
      if (toggle_en && i == 5) enable = 1'b1;
      @(negedge clk_400MHz);
    end
  endtask

  task automatic expect_slot(input string tag, input logic toggle_en, input logic [7:0] eb,
                             input logic ebusy, input logic [1:0] eid, input logic [1:0] eready);
    logic [7:0] b;
    logic       busy;
    logic [1:0] id;
    logic [1:0] rdy;
    int         serr;
    int         stray;
    read_slot(toggle_en, b, busy, id, serr, stray, rdy);
    chk({tag, " byte"},      32'(b),     32'(eb));
    chk({tag, " tx_busy"},   32'(busy),  32'(ebusy));
    chk({tag, " grant_id"},  32'(id),    32'(eid));
    chk({tag, " sync/stab"}, 32'(serr),  32'd0);
    chk({tag, " bnd_ready"}, 32'(rdy),   32'(eready));
    chk({tag, " stray_rdy"}, 32'(stray), 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    enable        = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_data  = 16'h2211;

    // Reset state, with requests present to show ready stays low.
    @(negedge clk_400MHz);
    chk("rst data_out",  32'(data_out),      32'd0);
    chk("rst byte_sync", 32'(byte_sync),     32'd1);
    chk("rst tx_busy",   32'(tx_busy),       32'd0);
    chk("rst grant_id",  32'(tx_grant_id),   32'd0);
    chk("rst req_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 2'b00;
    reset = 1'b0;

    // 32 idle clocks after release.
    for (int s = 0; s < 4; s++) expect_slot("idle", 1'b0, 8'h00, 1'b0, 2'd0, 2'b00);

    // Both requesters: requester 0 wins first after reset, then alternation.
    bus.req_valid = 2'b11;
    bus.req_data  = 16'h2211;
    expect_slot("rr pre", 1'b0, 8'h00, 1'b0, 2'd0, 2'b01);
    expect_slot("rr b0",  1'b0, 8'h11, 1'b1, 2'd0, 2'b10);
    expect_slot("rr b1",  1'b0, 8'h22, 1'b1, 2'd1, 2'b01);
    expect_slot("rr b2",  1'b0, 8'h11, 1'b1, 2'd0, 2'b10);
    bus.req_valid = 2'b00;
    expect_slot("rr b3",  1'b0, 8'h22, 1'b1, 2'd1, 2'b00);

    // Single requester 0 with A5.
    bus.req_valid = 2'b01;
    bus.req_data  = 16'h00A5;
    expect_slot("a5 pre", 1'b0, 8'h00, 1'b0, 2'd0, 2'b01);
    bus.req_valid = 2'b00;
    expect_slot("a5 byte", 1'b0, 8'hA5, 1'b1, 2'd0, 2'b00);

    // enable low for two slots while requester 1 waits; mid-slot toggle on the granted byte.
    bus.req_valid = 2'b10;
    bus.req_data  = 16'h5C00;
    enable = 1'b0;
    expect_slot("en off1", 1'b0, 8'h00, 1'b0, 2'd0, 2'b00);
    expect_slot("en off2", 1'b0, 8'h00, 1'b0, 2'd0, 2'b00);
    enable = 1'b1;
    expect_slot("en on",   1'b0, 8'h00, 1'b0, 2'd0, 2'b10);
    bus.req_valid = 2'b00;
    expect_slot("en byte", 1'b1, 8'h5C, 1'b1, 2'd1, 2'b00);

    // Reset in the middle of byte FF; resent after 8 idle clocks because valid stays high.
    bus.req_valid = 2'b10;
    bus.req_data  = 16'hFF00;
    expect_slot("ff pre", 1'b0, 8'h00, 1'b0, 2'd0, 2'b10);
    chk("ff busy", 32'(tx_busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ff bit", 32'(data_out), 32'd1);
      if (i < 3) @(negedge clk_400MHz);
    end
    reset = 1'b1;
    #1;
    chk("abort data_out",  32'(data_out),      32'd0);
    chk("abort byte_sync", 32'(byte_sync),     32'd1);
    chk("abort tx_busy",   32'(tx_busy),       32'd0);
    chk("abort req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk_400MHz);
    reset = 1'b0;
    expect_slot("ff idle", 1'b0, 8'h00, 1'b0, 2'd0, 2'b10);
    bus.req_valid = 2'b00;
    expect_slot("ff resend", 1'b0, 8'hFF, 1'b1, 2'd1, 2'b00);
    expect_slot("tail", 1'b0, 8'h00, 1'b0, 2'd0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
